// File: rtl/sdrc_arb_pkg.sv
// Shared types and constants for the SDRAM-controller Wishbone arbiter.
package sdrc_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin picker: searches upward from the slot after
// 'last' and returns the first requester as a one-hot grant plus its index.
module sdrc_rr_pick #(
   parameter int NM = 4,
   parameter int LW = $clog2(NM)
) (
   input  logic [NM-1:0] req,
   input  logic [LW-1:0] last,
   output logic [NM-1:0] gnt,
   output logic [LW-1:0] gnt_idx,
   output logic          valid
);

   logic [LW-1:0] idx;

   // Walk the request vector in rotating order, first hit wins
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      valid   = 1'b0;
      idx     = '0;
      for (int i = 1; i <= NM; i++) begin
         idx = LW'((int'(last) + i) % NM);
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdrc_wb_arb.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller slave port,
// with burst-aware grant holding and an ack-timeout watchdog.
module sdrc_wb_arb
   import sdrc_arb_pkg::*;
#(
   parameter int NM      = 4,
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int SW      = DW / 8,
   parameter int TIMEOUT = 1024
) (
   input  logic             sys_clk,
   input  logic             sdram_resetn,
   input  logic             sdr_init_done,
   input  logic [NM-1:0]    m_cyc_i,
   input  logic [NM-1:0]    m_stb_i,
   input  logic [NM-1:0]    m_we_i,
   input  logic [NM*AW-1:0] m_addr_i,
   input  logic [NM*DW-1:0] m_dat_i,
   input  logic [NM*SW-1:0] m_sel_i,
   input  logic [NM*3-1:0]  m_cti_i,
   output logic [DW-1:0]    m_dat_o,
   output logic [NM-1:0]    m_ack_o,
   output logic [NM-1:0]    m_err_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [AW-1:0]    s_addr_o,
   output logic [DW-1:0]    s_dat_o,
   output logic [SW-1:0]    s_sel_o,
   output logic [2:0]       s_cti_o,
   input  logic [DW-1:0]    s_dat_i,
   input  logic             s_ack_i,
   output logic [NM-1:0]    grant_o,
   output logic             busy_o
);

   localparam int LW = $clog2(NM);
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_e    state;
   arb_state_e    state_nxt;
   logic [LW-1:0] last;
   logic [LW-1:0] gidx;
   logic [CW-1:0] wd_cnt;

   logic [NM-1:0] req_vec;
   logic [NM-1:0] pick_gnt;
   logic [LW-1:0] pick_idx;
   logic          pick_valid;

   logic          g_cyc;
   logic          g_stb;
   logic          g_we;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_dat;
   logic [SW-1:0] g_sel;
   logic [2:0]    g_cti;
   logic          timeout;

   assign req_vec = m_cyc_i & m_stb_i & {NM{sdr_init_done}};

   sdrc_rr_pick #(.NM(NM), .LW(LW)) u_pick (
      .req     (req_vec),
      .last    (last),
      .gnt     (pick_gnt),
      .gnt_idx (pick_idx),
      .valid   (pick_valid)
   );

   assign g_cyc  = m_cyc_i[gidx];
   assign g_stb  = m_stb_i[gidx];
   assign g_we   = m_we_i[gidx];
   assign g_addr = m_addr_i[gidx*AW +: AW];
   assign g_dat  = m_dat_i[gidx*DW +: DW];
   assign g_sel  = m_sel_i[gidx*SW +: SW];
   assign g_cti  = m_cti_i[gidx*3 +: 3];

   // An ack landing on the limit cycle beats the abort
   assign timeout = (wd_cnt == CW'(TIMEOUT)) && !s_ack_i;

   assign m_dat_o = s_dat_i;
   assign busy_o  = (state != IDLE);

   // State register
   always_ff @(posedge sys_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) state <= IDLE;
      else               state <= state_nxt;
   end

   // Next state plus slave mux and per-master ack/err steering
   always_comb begin
      state_nxt = state;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_addr_o  = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      s_cti_o   = '0;
      m_ack_o   = '0;
      m_err_o   = '0;
      case (state)
         IDLE: begin
            if (pick_valid) state_nxt = BUSY;
         end
         BUSY: begin
            s_cyc_o  = g_cyc & ~timeout;
            s_stb_o  = g_stb & ~timeout;
            s_we_o   = g_we;
            s_addr_o = g_addr;
            s_dat_o  = g_dat;
            s_sel_o  = g_sel;
            s_cti_o  = g_cti;
            if (timeout) begin
               m_err_o[gidx] = 1'b1;
               state_nxt     = ABORT;
            end else begin
               m_ack_o[gidx] = s_ack_i;
               if (!g_cyc || (s_ack_i && g_cti == CTI_EOB)) state_nxt = IDLE;
            end
         end
         ABORT: begin
            if (!g_cyc) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant bookkeeping and the stalled-strobe watchdog
   always_ff @(posedge sys_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         grant_o <= '0;
         gidx    <= '0;
         last    <= LW'(NM - 1);
         wd_cnt  <= '0;
      end else if (state == IDLE) begin
         if (pick_valid) begin
            grant_o <= pick_gnt;
            gidx    <= pick_idx;
            last    <= pick_idx;
            wd_cnt  <= '0;
         end
      end else begin
         if (state_nxt == IDLE) grant_o <= '0;
         if (s_ack_i)           wd_cnt  <= '0;
         else if (s_stb_o)      wd_cnt  <= wd_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_sdrc_wb_arb.sv
// Self-checking bench for sdrc_wb_arb: directed scenarios plus a randomized
// phase compared against a transaction-level round-robin model.
module tb_sdrc_wb_arb;

   localparam int NM = 4;
   localparam int AW = 26;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             init_done;
   logic [NM-1:0]    m_cyc, m_stb, m_we;
   logic [NM*AW-1:0] m_addr;
   logic [NM*DW-1:0] m_dat;
   logic [NM*SW-1:0] m_sel;
   logic [NM*3-1:0]  m_cti;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o, m_err_o;
   logic             s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]    s_addr_o;
   logic [DW-1:0]    s_dat_o;
   logic [SW-1:0]    s_sel_o;
   logic [2:0]       s_cti_o;
   logic [DW-1:0]    s_dat;
   logic             s_ack;
   logic [NM-1:0]    grant_o;
   logic             busy_o;

   int checks   = 0;
   int failures = 0;

   int            owner;
   int            mlast;
   int            acks;
   int            stall;
   bit            act[NM];
   bit            ack_seen[NM];
   bit            rand_init;
   logic [NM-1:0] prev_grant;
   int            dut_q[$];

   always #5 clk = ~clk;

   sdrc_wb_arb #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
      .sys_clk       (clk),
      .sdram_resetn  (rst_n),
      .sdr_init_done (init_done),
      .m_cyc_i       (m_cyc),
      .m_stb_i       (m_stb),
      .m_we_i        (m_we),
      .m_addr_i      (m_addr),
      .m_dat_i       (m_dat),
      .m_sel_i       (m_sel),
      .m_cti_i       (m_cti),
      .m_dat_o       (m_dat_o),
      .m_ack_o       (m_ack_o),
      .m_err_o       (m_err_o),
      .s_cyc_o       (s_cyc_o),
      .s_stb_o       (s_stb_o),
      .s_we_o        (s_we_o),
      .s_addr_o      (s_addr_o),
      .s_dat_o       (s_dat_o),
      .s_sel_o       (s_sel_o),
      .s_cti_o       (s_cti_o),
      .s_dat_i       (s_dat),
      .s_ack_i       (s_ack),
      .grant_o       (grant_o),
      .busy_o        (busy_o)
   );

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_master(input int k, input logic [2:0] cti);
      m_cyc[k]             = 1'b1;
      m_stb[k]             = 1'b1;
      m_we[k]              = 1'($urandom_range(1, 0));
      m_addr[k*AW +: AW]   = AW'($urandom);
      m_dat[k*DW +: DW]    = $urandom;
      m_sel[k*SW +: SW]    = SW'($urandom);
      m_cti[k*3 +: 3]      = cti;
   endtask

   task automatic drop_master(input int k);
      m_cyc[k] = 1'b0;
      m_stb[k] = 1'b0;
   endtask

   // Classic single-beat masters, a random-latency slave, and a model that
   // predicts owner changes from the round-robin rule at transaction level.
   task automatic apply_stimulus(input int n, input int req_pct, input int ack_pct);
      logic [NM-1:0] eg;
      logic [AW-1:0] ea;
      logic          es;
      int            k;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (rand_init) init_done = ($urandom_range(7, 0) != 0);
         for (int j = 0; j < NM; j++) begin
            if (ack_seen[j]) begin
               act[j]      = 1'b0;
               ack_seen[j] = 1'b0;
               drop_master(j);
            end else if (!act[j] && int'($urandom_range(99, 0)) < req_pct) begin
               act[j] = 1'b1;
               start_master(j, 3'b000);
            end
         end
         s_ack = 1'b0;
         s_dat = $urandom;
         #1;
         if (s_stb_o) begin
            if (stall >= 8 || int'($urandom_range(99, 0)) < ack_pct) begin
               s_ack = 1'b1;
               stall = 0;
            end else begin
               stall++;
            end
         end
         #1;
         eg = '0;
         ea = '0;
         es = 1'b0;
         if (owner >= 0) begin
            eg[owner] = 1'b1;
            ea        = m_addr[owner*AW +: AW];
            es        = m_stb[owner];
         end
         check_output("rand_grant", grant_o, eg);
         check_output("rand_busy", busy_o, owner >= 0);
         check_output("rand_s_stb", s_stb_o, es);
         check_output("rand_s_addr", s_addr_o, ea);
         check_output("rand_m_ack", m_ack_o, s_ack ? eg : '0);
         check_output("rand_m_err", m_err_o, 0);
         check_output("rand_m_dat", m_dat_o, s_dat);
         if (grant_o != 0 && prev_grant == 0)
            for (int j = 0; j < NM; j++) if (grant_o[j]) dut_q.push_back(j);
         prev_grant = grant_o;
         for (int j = 0; j < NM; j++) if (m_ack_o[j]) ack_seen[j] = 1'b1;
         if (owner >= 0 && s_ack) acks++;
         @(posedge clk);
         if (owner >= 0) begin
            if (!m_cyc[owner]) begin
               check_output("acks_per_grant", acks, 1);
               owner = -1;
            end
         end else begin
            for (int i = 1; i <= NM; i++) begin
               k = (mlast + i) % NM;
               if (owner < 0 && init_done && m_cyc[k] && m_stb[k]) begin
                  owner = k;
                  mlast = k;
                  acks  = 0;
               end
            end
         end
      end
   endtask

   // Linear sequence of directed and randomized steps
   initial begin
      rst_n      = 1'b1;
      init_done  = 1'b0;
      m_cyc      = '0;
      m_stb      = '0;
      m_we       = '0;
      m_addr     = '0;
      m_dat      = '0;
      m_sel      = '0;
      m_cti      = '0;
      s_ack      = 1'b0;
      s_dat      = '0;
      owner      = -1;
      mlast      = NM - 1;
      acks       = 0;
      stall      = 0;
      rand_init  = 1'b0;
      prev_grant = '0;
      for (int j = 0; j < NM; j++) begin
         act[j]      = 1'b0;
         ack_seen[j] = 1'b0;
      end
      start_master(0, 3'b000);
      #1 rst_n = 1'b0;
      #1;
      check_output("reset_grant", grant_o, 0);
      check_output("reset_s_cyc", s_cyc_o, 0);
      check_output("reset_busy", busy_o, 0);
      check_output("reset_m_ack", m_ack_o, 0);

      // Init not done: request is held off
      @(negedge clk) rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #2;
         check_output("preinit_s_cyc", s_cyc_o, 0);
         check_output("preinit_grant", grant_o, 0);
      end
      @(negedge clk) init_done = 1'b1;
      #2 check_output("init_same_cycle_grant", grant_o, 0);
      @(negedge clk);
      #2;
      check_output("init_grant", grant_o, 4'b0001);
      check_output("init_s_cyc", s_cyc_o, 1);
      check_output("init_s_addr", s_addr_o, m_addr[0 +: AW]);
      s_ack = 1'b1;
      s_dat = $urandom;
      #1;
      check_output("init_m_ack", m_ack_o, 4'b0001);
      check_output("init_m_dat", m_dat_o, s_dat);
      @(negedge clk);
      s_ack = 1'b0;
      drop_master(0);
      @(negedge clk);
      #2 check_output("init_release", grant_o, 0);
      owner = -1;
      mlast = 0;

      // All masters requesting continuously: rotation starting after master 0
      dut_q.delete();
      apply_stimulus(20, 100, 100);
      check_output("order_len", dut_q.size() >= 5, 1);
      for (int i = 0; i < 5; i++)
         if (i < dut_q.size()) check_output("order", dut_q[i], (1 + i) % NM);

      // Random traffic with init_done wobbling, then drain
      rand_init = 1'b1;
      apply_stimulus(400, 40, 50);
      rand_init = 1'b0;
      init_done = 1'b1;
      apply_stimulus(30, 0, 100);

      // Master 2 incrementing burst holds off master 1
      @(negedge clk);
      start_master(2, 3'b010);
      m_we[2] = 1'b0;
      #2 check_output("burst_pre", grant_o, 0);
      @(negedge clk);
      start_master(1, 3'b000);
      #2;
      check_output("burst_grant", grant_o, 4'b0100);
      check_output("burst_s_cti", s_cti_o, 3'b010);
      check_output("burst_s_we", s_we_o, 0);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         m_cti[2*3 +: 3] = (b == 3) ? 3'b111 : 3'b010;
         s_ack = 1'b0;
         #2;
         check_output("burst_wait_grant", grant_o, 4'b0100);
         check_output("burst_wait_ack", m_ack_o, 0);
         @(negedge clk);
         s_ack = 1'b1;
         s_dat = $urandom;
         #2;
         check_output("burst_ack", m_ack_o, 4'b0100);
         check_output("burst_dat", m_dat_o, s_dat);
         check_output("burst_ack_grant", grant_o, 4'b0100);
      end
      @(negedge clk);
      s_ack = 1'b0;
      drop_master(2);
      #2 check_output("burst_release", grant_o, 0);
      @(negedge clk);
      #2 check_output("m1_after_burst", grant_o, 4'b0010);
      @(negedge clk);
      s_ack = 1'b1;
      #2 check_output("m1_ack", m_ack_o, 4'b0010);
      @(negedge clk);
      s_ack = 1'b0;
      drop_master(1);
      @(negedge clk);

      // Master 3 never acked: watchdog abort
      start_master(3, 3'b000);
      #2 check_output("to_pre", grant_o, 0);
      repeat (TO) begin
         @(negedge clk);
         #2;
         check_output("to_stall_stb", s_stb_o, 1);
         check_output("to_stall_err", m_err_o, 0);
      end
      @(negedge clk);
      #2;
      check_output("to_err", m_err_o, 4'b1000);
      check_output("to_s_cyc", s_cyc_o, 0);
      check_output("to_busy", busy_o, 1);
      repeat (3) begin
         @(negedge clk);
         #2;
         check_output("abort_err", m_err_o, 0);
         check_output("abort_busy", busy_o, 1);
         check_output("abort_s_stb", s_stb_o, 0);
      end
      @(negedge clk);
      drop_master(3);
      #2 check_output("abort_drop_busy", busy_o, 1);
      @(negedge clk);
      #2;
      check_output("abort_exit_busy", busy_o, 0);
      check_output("abort_exit_grant", grant_o, 0);

      // Ack landing exactly on the limit cycle
      start_master(0, 3'b010);
      repeat (TO) begin
         @(negedge clk);
         #2 check_output("aot_stall_stb", s_stb_o, 1);
      end
      @(negedge clk);
      s_ack = 1'b1;
      #2;
      check_output("aot_ack", m_ack_o, 4'b0001);
      check_output("aot_err", m_err_o, 0);
      check_output("aot_s_stb", s_stb_o, 1);
      repeat (5) begin
         @(negedge clk);
         s_ack = 1'b0;
         #2;
         check_output("aot_cont_grant", grant_o, 4'b0001);
         check_output("aot_cont_stb", s_stb_o, 1);
         check_output("aot_cont_err", m_err_o, 0);
      end
      @(negedge clk);
      m_cti[0 +: 3] = 3'b111;
      s_ack = 1'b1;
      #2 check_output("aot_eob_ack", m_ack_o, 4'b0001);
      @(negedge clk);
      s_ack = 1'b0;
      drop_master(0);
      #2 check_output("aot_release", grant_o, 0);

      // Asynchronous reset mid-burst, then master 0 first again
      @(negedge clk);
      start_master(1, 3'b010);
      @(negedge clk);
      #2 check_output("rst_burst_grant", grant_o, 4'b0010);
      @(negedge clk);
      s_ack = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check_output("rst_s_cyc", s_cyc_o, 0);
      check_output("rst_grant", grant_o, 0);
      check_output("rst_busy", busy_o, 0);
      check_output("rst_m_ack", m_ack_o, 0);
      s_ack = 1'b0;
      @(negedge clk);
      start_master(0, 3'b000);
      start_master(2, 3'b000);
      start_master(3, 3'b000);
      rst_n = 1'b1;
      #2 check_output("post_rst_idle", grant_o, 0);
      @(negedge clk);
      #2 check_output("post_rst_priority", grant_o, 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdrc_wb_arb.md
# sdrc_wb_arb

Round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller (`sdrc_top`) among `NM` bus masters. It sits on the system-clock side, directly in front of the controller's `wb_*` port, and holds requests off until SDRAM initialization completes. It also provides burst-aware grant holding (CTI) and an ack-timeout watchdog that aborts a hung cycle with `err`.

## Interface
Parameters:
- `NM`, 4, number of masters (2..8)
- `AW`, 26, Wishbone address width
- `DW`, 32, data width; `SW = DW/8` select width
- `TIMEOUT`, 1024, cycles without `s_ack_i` while `s_stb_o` is high before abort (must be ≥ 2)

Ports:
- `sys_clk`  in  1  system/Wishbone clock; one clock, all logic on rising edge
- `sdram_resetn`  in  1  asynchronous active-low reset
- `sdr_init_done`  in  1  controller init complete; no grant is issued while low
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  NM each  per-master cycle, strobe and write-enable
- `m_addr_i`  in  NM*AW  packed per-master address, master k at `[k*AW +: AW]`
- `m_dat_i`  in  NM*DW  packed per-master write data
- `m_sel_i`  in  NM*SW  packed per-master byte select
- `m_cti_i`  in  NM*3  packed per-master cycle type
- `m_dat_o`  out  DW  read data, broadcast to all masters (= `s_dat_i`)
- `m_ack_o`, `m_err_o`  out  NM  per-master ack / error
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  to controller
- `s_addr_o`, `s_dat_o`, `s_sel_o`, `s_cti_o`  out  AW/DW/SW/3  to controller
- `s_dat_i`, `s_ack_i`  in  DW/1  from controller
- `grant_o`  out  NM  one-hot registered grant (all-zero when idle)
- `busy_o`  out  1  high in BUSY or ABORT

## Operation
- States: IDLE, BUSY, ABORT.
- IDLE: if `sdr_init_done` and any `m_cyc_i[k] & m_stb_i[k]`, pick the winner by round-robin, starting at `(last+1) mod NM`. Register `grant_o`, set `last` = winner, go to BUSY.
- BUSY: `s_*` outputs are a mux of the granted master's signals. `s_cyc_o = m_cyc_i[g]`, `s_stb_o = m_stb_i[g]`. `m_ack_o[g] = s_ack_i`, and other masters' ack/err are 0.
- Leave BUSY to IDLE when any of these holds:
  - `m_cyc_i[g]` is low, or
  - `s_ack_i` occurs with the granted CTI = 3'b111 (end of burst).
- The grant is held across CTI 3'b010 incrementing bursts and across classic cycles for as long as `cyc` stays high.
- Watchdog: an `$clog2(TIMEOUT+1)`-bit counter clears on grant and on every `s_ack_i`, and increments while `s_stb_o & ~s_ack_i`. When it reaches `TIMEOUT`:
  - pulse `m_err_o[g]` for one cycle
  - force `s_cyc_o`/`s_stb_o` low
  - go to ABORT
- ABORT: all `s_*` strobes stay low. Return to IDLE once `m_cyc_i[g]` is low, so the aborted master cannot be silently re-granted mid-cycle.
- When not in BUSY, every `s_*` output is 0 and every `m_ack_o`/`m_err_o` is 0.
- If `sdr_init_done` falls during BUSY, the current grant completes normally and no new grant is issued.

## Timing
- Reset values:
  - state IDLE, `grant_o` = 0, `last` = NM-1 (so master 0 has first priority)
  - watchdog counter 0, `busy_o` 0, all `s_*` outputs 0, `m_ack_o` 0, `m_err_o` 0
- Arbitration latency: a request sampled in IDLE in cycle n gives `grant_o` and `s_stb_o` in cycle n+1.
- Data path is combinational through the grant mux: zero added latency on ack and on read data.
- Between consecutive grants there is exactly one IDLE cycle.
- Simultaneous requests: a single winner per round-robin order. A losing request stays pending and is never dropped.
- `m_err_o` and `m_ack_o` are never asserted for the same master in the same cycle. If `s_ack_i` arrives on the timeout cycle, the ack wins and the counter clears.
- Asynchronous reset mid-transaction: all outputs clear immediately, without waiting for the clock.

## Structure
- Package `sdrc_arb_pkg`:
  - state enum `arb_state_e` {IDLE, BUSY, ABORT}
  - CTI constants `CTI_CLASSIC` = 3'b000, `CTI_INCR` = 3'b010, `CTI_EOB` = 3'b111
- Sub-module `sdrc_rr_pick`: combinational picker. Inputs are an `NM`-bit request vector and the `last` index. Outputs are a one-hot grant and a `valid` flag. Reusable by other arbiters.

## Test plan
- Reset release with `sdr_init_done` = 0 and master 0 requesting: no `s_cyc_o` is driven. Raise `sdr_init_done` → `grant_o` = 4'b0001 one cycle later.
- Masters 0–3 all requesting single classic writes continuously → grants issue in order 0, 1, 2, 3, 0, with one IDLE cycle between grants. Each master receives exactly one ack per grant.
- Master 2 issues a 4-beat CTI 010/010/010/111 read burst while master 1 also requests → master 1 stays ungranted until the ack with CTI 111. `m_dat_o` equals `s_dat_i` on each of the 4 acks.
- Master 3 starts a cycle and the controller never acks, with `TIMEOUT` = 16 → after 16 cycles of stalled stb, `m_err_o[3]` pulses once and the arbiter enters ABORT. It returns to IDLE one cycle after master 3 drops cyc.
- `sdram_resetn` is asserted mid-burst → `s_cyc_o`, `grant_o` and `busy_o` go to 0 immediately. After release, master 0 has first priority again.
- Ack arrives exactly on the timeout cycle → `m_ack_o` is asserted, `m_err_o` stays 0, and the transfer continues.
